fetch_queue: RTL

Instruction prefetch stage between instruction memory and the decode stage. It issues sequential fetch requests, tracks in-flight responses, and buffers returned instructions with their PC in a small FIFO. It presents instructions to decode under a valid/ready handshake and flushes cleanly on a jump redirect from the execute/PC logic.

---
 rtl/fetch_queue.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch with credit-limited in-flight tracking,
// a {instr, pc} FIFO toward decode, and redirect flush with stale-response dropping.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [15:0]   fetch_pc, resp_pc;
  logic [CW-1:0] inflight, drop, count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [CW:0]   used;
  logic          issue, push, pop;
  // every queued or outstanding instruction holds a credit, so pushes never need a full check
  assign used        = {1'b0, count} + {1'b0, inflight};
  assign issue       = !reset && !redirect && drop == '0 && used < (CW+1)'(DEPTH);
  assign push        = imem_valid && drop == '0 && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign imem_req    = issue;
  assign imem_addr   = issue ? fetch_pc : 16'h0000;
  assign instr_valid = count != '0;
  assign instr       = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_valid);
      if (issue) fetch_pc <= fetch_pc + 16'd1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop     <= inflight - CW'(imem_valid);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (imem_valid && drop != '0) drop <= drop - 1'b1;
        if (push) begin
          data_q[wr_ptr] <= imem_rdata;
          pc_q[wr_ptr]   <= resp_pc;
          wr_ptr         <= wr_ptr + 1'b1;
          resp_pc        <= resp_pc + 16'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
